// File: rtl/ccc_lock_supervisor.sv
// Fabric-side supervisor for the CCC lock. It synchronizes LOCK_IN and qualifies it over a
// stability window. It then sequences SYS_RESET release and counts lock losses seen in RUN.
module ccc_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4096,
  parameter int RELEASE_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOCK_IN,
  input  logic             CLR_CNT,
  output logic             SYS_RESET,
  output logic             CLK_GOOD,
  output logic             LOSS_IRQ,
  output logic [CNT_W-1:0] LOSS_CNT,
  output logic [2:0]       STATE
);

  localparam int TCNT_MAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
  localparam int TCNT_W   = $clog2(TCNT_MAX + 1);

  localparam logic [TCNT_W-1:0] STABLE_LAST  = TCNT_W'(STABLE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] RELEASE_LAST = TCNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    QUALIFY   = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state_q, state_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  logic                   loss_event;
  logic [CNT_W-1:0]       loss_cnt_q;

  // LOCK_IN is sampled only here; everything downstream uses lock_s.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would collapse the synchronizer chain into a single stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK_IN};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= WAIT_LOCK;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // A lock drop has priority over the window-complete test in QUALIFY and RELEASE.
  // NOTE: defaults are assigned first so every path drives state_d and tcnt_d, which
  // prevents latch inference when a branch leaves either one untouched.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        tcnt_d = '0;
        if (lock_s) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          tcnt_d  = '0;
        end else if (tcnt_q == STABLE_LAST) begin
          state_d = RELEASE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          tcnt_d  = '0;
        end else if (tcnt_q == RELEASE_LAST) begin
          state_d = RUN;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      RUN: begin
        tcnt_d = '0;
        if (!lock_s) state_d = LOST;
      end
      LOST: begin
        tcnt_d  = '0;
        state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        tcnt_d  = '0;
      end
    endcase
  end

  // Only a drop seen in RUN is a loss; earlier drops restart qualification silently.
  assign loss_event = (state_q == RUN) && !lock_s;

  // A clear that coincides with a loss still records the new loss.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      loss_cnt_q <= '0;
    end else if (CLR_CNT) begin
      loss_cnt_q <= loss_event ? CNT_W'(1) : '0;
    end else if (loss_event && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + CNT_W'(1);
    end
  end

  assign SYS_RESET = (state_q != RUN);
  assign CLK_GOOD  = (state_q == RUN);
  assign LOSS_IRQ  = (state_q == LOST);
  assign LOSS_CNT  = loss_cnt_q;
  assign STATE     = state_q;

`ifndef SYNTHESIS
  a_lost_one_cycle: assert property (
    @(posedge CLK) disable iff (RESET) (state_q == LOST) |=> (state_q == WAIT_LOCK));
  a_tcnt_in_window: assert property (
    @(posedge CLK) disable iff (RESET) (state_q == QUALIFY) |-> (tcnt_q <= STABLE_LAST));
`endif

endmodule
